// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Request/response bundle between an ALU client and alu_seq.
//               The master issues operations and takes results; the slave
//               is the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic            is_reg;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            err;

  modport master (
    output in_valid, rs1, rs2, imm, is_reg, funct3, funct7, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, rs1, rs2, imm, is_reg, funct3, funct7, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : RV32/RV64 integer ALU with valid/ready handshake. Logic and
//               arithmetic ops finish in one cycle, shifts iterate
//               SHIFT_STEP bits per cycle. Define ALU_MULDIV_EN to build the
//               iterative M-extension multiplier/divider; without it an
//               M-encoded request returns result 0 with err set.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic       clk,
  input logic       resetn,
  alu_seq_if.slave  bus
);
  localparam int LOG2 = $clog2(XLEN);
  localparam int CW   = LOG2 + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    MULDIV = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] sh_val_q, sh_val_d;
  logic [LOG2-1:0] sh_cnt_q, sh_cnt_d;
  logic            sh_left_q, sh_left_d;
  logic            sh_arith_q, sh_arith_d;

  logic            w_in_ready, w_accept, w_is_m, w_alt;
  logic [XLEN-1:0] w_b, w_alu;
  logic [LOG2-1:0] w_shamt;
  logic [CW-1:0]   w_cnt_ext, w_sh_amt;
  logic            w_sh_last;
  logic [LOG2-1:0] w_sh_cnt_next;
  logic [XLEN-1:0] w_sra, w_sh_next;

  assign w_in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_b        = bus.is_reg ? bus.rs2 : bus.imm;
  assign w_shamt    = w_b[LOG2-1:0];
  assign w_is_m     = bus.is_reg && (bus.funct7 == 7'b0000001);
  assign w_alt      = bus.funct7[5];

  // Single-cycle arithmetic/logic result for the incoming request.
  always_comb begin
    w_alu = '0;
    case (bus.funct3)
      3'b000:  w_alu = (bus.is_reg && w_alt) ? (bus.rs1 - w_b) : (bus.rs1 + w_b);
      3'b010:  w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.rs1) < $signed(w_b))};
      3'b011:  w_alu = {{(XLEN-1){1'b0}}, (bus.rs1 < w_b)};
      3'b100:  w_alu = bus.rs1 ^ w_b;
      3'b110:  w_alu = bus.rs1 | w_b;
      3'b111:  w_alu = bus.rs1 & w_b;
      default: w_alu = '0;
    endcase
  end

  // One shift iteration: min(SHIFT_STEP, remaining) positions.
  assign w_cnt_ext     = {1'b0, sh_cnt_q};
  assign w_sh_last     = (w_cnt_ext <= STEP_C);
  assign w_sh_amt      = w_sh_last ? w_cnt_ext : STEP_C;
  assign w_sh_cnt_next = w_sh_last ? '0 : (sh_cnt_q - w_sh_amt[LOG2-1:0]);
  assign w_sra         = $signed(sh_val_q) >>> w_sh_amt;

  // Select the shifted value by direction and fill type.
  always_comb begin
    if (sh_left_q)       w_sh_next = sh_val_q << w_sh_amt;
    else if (sh_arith_q) w_sh_next = w_sra;
    else                 w_sh_next = sh_val_q >> w_sh_amt;
  end

`ifdef ALU_MULDIV_EN
  // Shared product / remainder:quotient register; operand is the magnitude of
  // the multiplicand or divisor, signs are folded back in on the last cycle.
  logic [2*XLEN-1:0] md_prod_q, md_prod_d;
  logic [XLEN-1:0]   md_opnd_q, md_opnd_d;
  logic [XLEN-1:0]   md_rs1_q, md_rs1_d;
  logic [CW-1:0]     md_cnt_q, md_cnt_d;
  logic [2:0]        md_f3_q, md_f3_d;
  logic              md_neg_q, md_neg_d;
  logic              md_bz_q, md_bz_d;

  logic [XLEN:0]     w_mul_sum, w_div_trial;
  logic [2*XLEN-1:0] w_md_step, w_prod_fix;
  logic [XLEN-1:0]   w_q_fix, w_r_fix, w_md_result, w_abs_a, w_abs_b;
  logic              w_a_sgn, w_b_sgn, w_sa, w_sb;

  assign w_a_sgn = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign w_b_sgn = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
  assign w_sa    = w_a_sgn && bus.rs1[XLEN-1];
  assign w_sb    = w_b_sgn && bus.rs2[XLEN-1];
  assign w_abs_a = w_sa ? (-bus.rs1) : bus.rs1;
  assign w_abs_b = w_sb ? (-bus.rs2) : bus.rs2;

  assign w_mul_sum   = {1'b0, md_prod_q[2*XLEN-1:XLEN]} +
                       (md_prod_q[0] ? {1'b0, md_opnd_q} : {(XLEN+1){1'b0}});
  assign w_div_trial = md_prod_q[2*XLEN-1:XLEN-1] - {1'b0, md_opnd_q};
  assign w_prod_fix  = md_neg_q ? (-md_prod_q) : md_prod_q;
  assign w_q_fix     = md_neg_q ? (-md_prod_q[XLEN-1:0]) : md_prod_q[XLEN-1:0];
  assign w_r_fix     = md_neg_q ? (-md_prod_q[2*XLEN-1:XLEN]) : md_prod_q[2*XLEN-1:XLEN];

  // One shift-add multiply step or one restoring divide step.
  always_comb begin
    if (!md_f3_q[2])               w_md_step = {w_mul_sum, md_prod_q[XLEN-1:1]};
    else if (!w_div_trial[XLEN])   w_md_step = {w_div_trial[XLEN-1:0], md_prod_q[XLEN-2:0], 1'b1};
    else                           w_md_step = {md_prod_q[2*XLEN-2:0], 1'b0};
  end

  // Final sign correction and divide-by-zero handling.
  always_comb begin
    case (md_f3_q)
      3'b000:                 w_md_result = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_md_result = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_md_result = md_bz_q ? {XLEN{1'b1}} : w_q_fix;
      default:                w_md_result = md_bz_q ? md_rs1_q : w_r_fix;
    endcase
  end
`endif

  // Next-state and datapath for the whole controller.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    sh_val_d    = sh_val_q;
    sh_cnt_d    = sh_cnt_q;
    sh_left_d   = sh_left_q;
    sh_arith_d  = sh_arith_q;
`ifdef ALU_MULDIV_EN
    md_prod_d = md_prod_q;
    md_opnd_d = md_opnd_q;
    md_rs1_d  = md_rs1_q;
    md_cnt_d  = md_cnt_q;
    md_f3_d   = md_f3_q;
    md_neg_d  = md_neg_q;
    md_bz_d   = md_bz_q;
`endif
    case (state_q)
      IDLE: ;
      SHIFT: begin
        sh_val_d = w_sh_next;
        sh_cnt_d = w_sh_cnt_next;
        if (w_sh_last) begin
          result_d    = w_sh_next;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      MULDIV: begin
`ifdef ALU_MULDIV_EN
        // XLEN iterations then one fix-up cycle.
        if (md_cnt_q == CW'(XLEN)) begin
          result_d    = w_md_result;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          md_prod_d = w_md_step;
          md_cnt_d  = md_cnt_q + CW'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request overrides the retire path of DONE.
    if (w_accept) begin
      err_d       = 1'b0;
      out_valid_d = 1'b0;
      if (w_is_m) begin
`ifdef ALU_MULDIV_EN
        md_f3_d  = bus.funct3;
        md_cnt_d = '0;
        md_rs1_d = bus.rs1;
        md_bz_d  = (bus.rs2 == '0);
        if (!bus.funct3[2]) begin
          md_prod_d = {{XLEN{1'b0}}, w_abs_b};
          md_opnd_d = w_abs_a;
          md_neg_d  = w_sa ^ w_sb;
        end else begin
          md_prod_d = {{XLEN{1'b0}}, w_abs_a};
          md_opnd_d = w_abs_b;
          md_neg_d  = bus.funct3[1] ? w_sa : (w_sa ^ w_sb);
        end
        state_d = MULDIV;
`else
        result_d    = '0;
        err_d       = 1'b1;
        out_valid_d = 1'b1;
        state_d     = DONE;
`endif
      end else if (bus.funct3[1:0] == 2'b01) begin
        if (w_shamt == '0) begin
          result_d    = bus.rs1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          sh_val_d   = bus.rs1;
          sh_cnt_d   = w_shamt;
          sh_left_d  = !bus.funct3[2];
          sh_arith_d = w_alt;
          state_d    = SHIFT;
        end
      end else begin
        result_d    = w_alu;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
    end
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      result_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sh_val_q    <= '0;
      sh_cnt_q    <= '0;
      sh_left_q   <= 1'b0;
      sh_arith_q  <= 1'b0;
`ifdef ALU_MULDIV_EN
      md_prod_q <= '0;
      md_opnd_q <= '0;
      md_rs1_q  <= '0;
      md_cnt_q  <= '0;
      md_f3_q   <= '0;
      md_neg_q  <= 1'b0;
      md_bz_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      sh_val_q    <= sh_val_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_left_q   <= sh_left_d;
      sh_arith_q  <= sh_arith_d;
`ifdef ALU_MULDIV_EN
      md_prod_q <= md_prod_d;
      md_opnd_q <= md_opnd_d;
      md_rs1_q  <= md_rs1_d;
      md_cnt_q  <= md_cnt_d;
      md_f3_q   <= md_f3_d;
      md_neg_q  <= md_neg_d;
      md_bz_q   <= md_bz_d;
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Bench for alu_seq. Two instances (SHIFT_STEP 1 and 4) receive
//               identical requests; results, err and latency are compared
//               against an arithmetic reference model. Honors ALU_MULDIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_res;
  logic        exp_err;
  int          exp_l1, exp_l4;
  logic [31:0] obs_res1;
  logic [31:0] corners [4] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF};

  alu_seq_if #(.XLEN(32)) if1 ();
  alu_seq_if #(.XLEN(32)) if4 ();

  alu_seq #(.XLEN(32), .SHIFT_STEP(1)) u_dut1 (.clk(clk), .resetn(resetn), .bus(if1));
  alu_seq #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (.clk(clk), .resetn(resetn), .bus(if4));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: RISC-V semantics written with plain integer arithmetic.
  task automatic model(input logic [31:0] a, input logic [31:0] br, input logic [31:0] bi,
                       input logic isr, input logic [2:0] f3, input logic [6:0] f7);
    logic [31:0] b;
    int sh;
`ifdef ALU_MULDIV_EN
    longint sa, sb, p;
    logic [63:0] u;
`endif
    b = isr ? br : bi;
    sh = int'(b[4:0]);
    exp_err = 1'b0;
    exp_l1 = 1;
    exp_l4 = 1;
    exp_res = 32'h0;
    if (isr && f7 == 7'h01) begin
`ifdef ALU_MULDIV_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      exp_l1 = 34;
      exp_l4 = 34;
      case (f3)
        3'd0: begin p = sa * sb; exp_res = p[31:0]; end
        3'd1: begin p = sa * sb; exp_res = p[63:32]; end
        3'd2: begin p = sa * longint'({32'h0, b}); exp_res = p[63:32]; end
        3'd3: begin u = {32'h0, a} * {32'h0, b}; exp_res = u[63:32]; end
        3'd4: begin
          if (b == 0) exp_res = 32'hFFFF_FFFF;
          else begin p = sa / sb; exp_res = p[31:0]; end
        end
        3'd5: exp_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: begin
          if (b == 0) exp_res = a;
          else begin p = sa % sb; exp_res = p[31:0]; end
        end
        default: exp_res = (b == 0) ? a : a % b;
      endcase
`else
      exp_err = 1'b1;
`endif
    end else begin
      case (f3)
        3'd0: exp_res = (isr && f7[5]) ? a - b : a + b;
        3'd2: exp_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: exp_res = (a < b) ? 32'd1 : 32'd0;
        3'd4: exp_res = a ^ b;
        3'd6: exp_res = a | b;
        3'd7: exp_res = a & b;
        3'd1: exp_res = a << sh;
        default: exp_res = f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
      endcase
      if (f3 == 3'd1 || f3 == 3'd5) begin
        exp_l1 = 1 + sh;
        exp_l4 = 1 + (sh + 3) / 4;
      end
    end
  endtask

  task automatic set_fields(input logic [31:0] a, input logic [31:0] br, input logic [31:0] bi,
                            input logic isr, input logic [2:0] f3, input logic [6:0] f7);
    if1.rs1 = a;  if1.rs2 = br; if1.imm = bi; if1.is_reg = isr; if1.funct3 = f3; if1.funct7 = f7;
    if4.rs1 = a;  if4.rs2 = br; if4.imm = bi; if4.is_reg = isr; if4.funct3 = f3; if4.funct7 = f7;
  endtask

  task automatic set_valid(input logic v);
    if1.in_valid = v;
    if4.in_valid = v;
  endtask

  task automatic set_oready(input logic v);
    if1.out_ready = v;
    if4.out_ready = v;
  endtask

  // After the accept edge: present and model then garble the inputs.
  task automatic post_accept();
    #1;
    set_valid(1'b0);
    set_fields($urandom, $urandom, $urandom, 1'($urandom), 3'($urandom), 7'($urandom));
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] br, input logic [31:0] bi,
                       input logic isr, input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    set_fields(a, br, bi, isr, f3, f7);
    set_valid(1'b1);
    model(a, br, bi, isr, f3, f7);
    @(posedge clk);
    post_accept();
  endtask

  // Called 1 time unit after the accept edge; counts edges until out_valid.
  task automatic collect();
    int n = 1;
    bit d1 = 0, d4 = 0;
    int lat1 = 0, lat4 = 0;
    while (!(d1 && d4) && n <= 80) begin
      if (!d1 && if1.out_valid) begin d1 = 1; lat1 = n; end
      if (!d4 && if4.out_valid) begin d4 = 1; lat4 = n; end
      if (!(d1 && d4)) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("latency_step1", 64'(lat1), 64'(exp_l1));
    check("latency_step4", 64'(lat4), 64'(exp_l4));
    check("result_step1", 64'(if1.result), 64'(exp_res));
    check("result_step4", 64'(if4.result), 64'(exp_res));
    check("err_step1", 64'(if1.err), 64'(exp_err));
    check("err_step4", 64'(if4.err), 64'(exp_err));
    obs_res1 = if1.result;
  endtask

  task automatic retire();
    @(negedge clk);
    set_oready(1'b1);
    @(posedge clk);
    #1;
    set_oready(1'b0);
    check("retire_valid", 64'({if1.out_valid, if4.out_valid}), 64'(0));
    check("retire_ready", 64'({if1.in_ready, if4.in_ready}), 64'(3));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] br, input logic [31:0] bi,
                        input logic isr, input logic [2:0] f3, input logic [6:0] f7);
    issue(a, br, bi, isr, f3, f7);
    collect();
    retire();
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) == 0) v = corners[$urandom_range(0, 3)];
    return v;
  endfunction

  initial begin
    logic [31:0] held;
    logic [11:0] i12;
    bit stale;
    resetn = 1'b0;
    set_valid(1'b0);
    set_oready(1'b0);
    set_fields('0, '0, '0, 1'b0, 3'd0, 7'd0);
    #1;
    check("reset_outputs", 64'({if1.out_valid, if1.err, if1.in_ready, if4.in_ready}), 64'(3));
    check("reset_result", 64'(if1.result), 64'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Directed arithmetic and compare cases.
    run_op(32'd5, 32'd7, 32'd0, 1'b1, 3'd0, 7'h00);
    check("add_spec", 64'(obs_res1), 64'd12);
    run_op(32'd5, 32'd7, 32'd0, 1'b1, 3'd0, 7'h20);
    check("sub_spec", 64'(obs_res1), 64'hFFFF_FFFE);
    run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 3'd0, 7'h20);
    check("addi_spec", 64'(obs_res1), 64'd4);
    run_op(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 3'd2, 7'h00);
    check("slt_spec", 64'(obs_res1), 64'd1);
    run_op(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 3'd3, 7'h00);
    check("sltu_spec", 64'(obs_res1), 64'd0);
    run_op(32'h8000_0000, 32'd4, 32'd0, 1'b1, 3'd5, 7'h20);
    check("sra_spec", 64'(obs_res1), 64'hF800_0000);
    run_op(32'h1234_5678, 32'd0, 32'd0, 1'b1, 3'd1, 7'h00);
    run_op(32'hF0F0_1234, 32'd0, 32'd31, 1'b0, 3'd5, 7'h00);
    run_op(32'h0000_0001, 32'd31, 32'd0, 1'b1, 3'd1, 7'h00);

    // M-encoded requests (computed or rejected depending on the build).
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 3'd4, 7'h01);
    run_op(32'd9, 32'd0, 32'd0, 1'b1, 3'd5, 7'h01);
    run_op(32'd7, 32'd0, 32'd0, 1'b1, 3'd6, 7'h01);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 3'd1, 7'h01);
    run_op(32'hFFFF_FFF9, 32'd3, 32'd0, 1'b1, 3'd0, 7'h01);
    run_op(32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 3'd6, 7'h01);

    // Backpressure, then retire and accept on the same edge.
    issue(32'h8000_0010, 32'd7, 32'd0, 1'b1, 3'd5, 7'h20);
    collect();
    held = if1.result;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("hold_result", 64'({if1.result, if4.result}), 64'({held, held}));
      check("hold_flags", 64'({if1.out_valid, if1.in_ready, if4.out_valid, if4.in_ready}), 64'b1010);
    end
    @(negedge clk);
    set_fields(32'd100, 32'd23, 32'd0, 1'b1, 3'd0, 7'h20);
    set_valid(1'b1);
    set_oready(1'b1);
    model(32'd100, 32'd23, 32'd0, 1'b1, 3'd0, 7'h20);
    @(posedge clk);
    post_accept();
    set_oready(1'b0);
    collect();
    retire();

    // Randomized requests.
    for (int k = 0; k < 40; k++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'h01;
      endcase
      i12 = 12'($urandom);
      run_op(pick(), pick(), {{20{i12[11]}}, i12}, 1'($urandom), 3'($urandom_range(0, 7)), f7);
    end

    // Reset in the middle of a long shift.
    issue(32'h8000_0000, 32'd31, 32'd0, 1'b1, 3'd5, 7'h20);
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_flags", 64'({if1.out_valid, if1.in_ready, if4.out_valid, if4.in_ready}), 64'b0101);
    check("rst_mid_result", 64'({if1.result, if1.err, if4.result, if4.err}), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    set_fields(32'd3, 32'd4, 32'd0, 1'b1, 3'd0, 7'h00);
    set_valid(1'b1);
    model(32'd3, 32'd4, 32'd0, 1'b1, 3'd0, 7'h00);
    @(posedge clk);
    post_accept();
    collect();
    retire();
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (if1.out_valid || if4.out_valid) stale = 1;
    end
    check("no_stale_result", 64'(stale), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SHIFT_STEP, default 1, bit positions shifted per iterative cycle; power of two, 1..XLEN.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 rs1  input  XLEN  operand A.
REQ-008 rs2  input  XLEN  register operand B.
REQ-009 imm  input  XLEN  sign-extended immediate operand B.
REQ-010 is_reg  input  1  1 = B from rs2 (R-type), 0 = B from imm (I-type).
REQ-011 funct3  input  3  operation select.
REQ-012 funct7  input  7  modifier; bit5 = alternate op, 7'b0000001 with is_reg = M-extension op.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer takes the result.
REQ-015 result  output  XLEN  operation result.
REQ-016 err  output  1  unsupported operation flag, qualified by out_valid.

Function
REQ-017 A request is accepted on a rising edge with in_valid and in_ready both high; all inputs are captured at that edge, later input changes have no effect.
REQ-018 in_ready is high in IDLE, and in DONE when out_ready is high (retire and accept on the same edge); low otherwise.
REQ-019 States: IDLE, SHIFT, MULDIV, DONE; IDLE->DONE for single-cycle ops, IDLE->SHIFT for shifts with shamt>0, IDLE->MULDIV for M ops, SHIFT/MULDIV->DONE on completion, DONE->IDLE on out_ready with no new accept, DONE->(DONE|SHIFT|MULDIV) on simultaneous retire and accept.
REQ-020 Operand B = is_reg ? rs2 : imm; shamt = B[log2(XLEN)-1:0].
REQ-021 funct3 000: ADD, or SUB when is_reg and funct7[5]; funct7[5] ignored for I-type; wrap modulo 2^XLEN.
REQ-022 funct3 010 SLT signed, 011 SLTU unsigned; result 1 or 0, zero-extended.
REQ-023 funct3 100 XOR, 110 OR, 111 AND.
REQ-024 funct3 001 SLL; 101 SRL, or SRA when funct7[5]; sign fill for SRA.
REQ-025 Shifts iterate min(SHIFT_STEP, remaining) positions per cycle; out_valid rises 1+ceil(shamt/SHIFT_STEP) clocks after accept; shamt=0 takes 1 clock and returns rs1.
REQ-026 Single-cycle ops: out_valid rises 1 clock after accept.
REQ-027 In DONE, result, err and out_valid hold stable until out_ready is high at a rising edge.
REQ-028 err is 0 for every base operation.

Reset
REQ-029 resetn low immediately forces state IDLE, out_valid=0, result=0, err=0, in_ready=1 (no clock required).
REQ-030 Reset during SHIFT, MULDIV or DONE discards the operation; no result is ever presented for it.
REQ-031 First accept is possible on the first rising edge after resetn deasserts.

Configuration
REQ-032 Macro ALU_MULDIV_EN compiles in the M extension; without it no multiplier or divider logic exists.
REQ-033 With ALU_MULDIV_EN, M ops use funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU, per the RISC-V M semantics.
REQ-034 With ALU_MULDIV_EN, M ops are iterative shift-add/restoring; out_valid rises exactly XLEN+2 clocks after accept, for all operand values.
REQ-035 Division by zero: quotient all ones, remainder = dividend; signed overflow (most-negative / -1): quotient = dividend, remainder 0; err stays 0.
REQ-036 Without ALU_MULDIV_EN, an M-encoded request completes in 1 clock with result=0, err=1.

Verification
REQ-037 XLEN=32: ADD rs1=5 rs2=7 -> result 12 one clock later; SUB same -> 0xFFFFFFFE; ADDI imm=-1 funct7[5]=1 -> 4.
REQ-038 SLT rs1=0xFFFFFFFF rs2=1 -> 1; SLTU same -> 0.
REQ-039 SHIFT_STEP=1: SRA rs1=0x80000000 shamt 4 -> 0xF8000000, out_valid 5 clocks after accept; SHIFT_STEP=4 same -> 2 clocks; SLL shamt 0 -> rs1 in 1 clock.
REQ-040 Hold out_ready low 3 cycles: result stable, in_ready low; then out_ready=1 with in_valid=1 -> retire and accept on the same edge, no bubble.
REQ-041 ALU_MULDIV_EN: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; DIVU 9/0 -> 0xFFFFFFFF; REM 7/0 -> 7; MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; each after 34 clocks; without macro MUL -> result 0, err 1, 1 clock.
REQ-042 Assert resetn low mid-SHIFT: out_valid 0 and in_ready 1 immediately, no stale result after release.
